// File: rtl/seq_pattern_gen.sv
// Serial frame source for the sliding-window sequence detector.
// Emits 1110 (01)^N 11, one bit per clock; negative frames end in 10 instead.
module seq_pattern_gen #(
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [REP_W-1:0] rep,
  input  logic             neg,
  input  logic             abort,
  output logic             ready,
  output logic             valid,
  output logic             out,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_MID  = 2'd2,
    ST_TAIL = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [REP_W-1:0] r_pair_cnt;
  logic [REP_W-1:0] r_rep_q;
  logic             r_neg_q;
  logic             r_out;
  logic             r_valid;
  logic             r_done;

  logic             w_last_bit;
  logic             w_accept;

  // The registered state always describes the bit currently on out, so the
  // final tail bit is also the cycle where a follow-on frame can be accepted.
  assign w_last_bit = (r_state == ST_TAIL) && (r_idx == 2'd1);
  assign ready      = (r_state == ST_IDLE) || w_last_bit;
  assign w_accept   = start && ready && (rep != {REP_W{1'b0}});

  assign out   = r_out;
  assign valid = r_valid;
  assign done  = r_done;

  // Frame sequencer: state, counters and registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= 2'd0;
      r_pair_cnt <= {REP_W{1'b0}};
      r_rep_q    <= {REP_W{1'b0}};
      r_neg_q    <= 1'b0;
      r_out      <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else if (abort) begin
      r_state    <= ST_IDLE;
      r_idx      <= 2'd0;
      r_pair_cnt <= {REP_W{1'b0}};
      r_out      <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else if (w_accept) begin
      r_state    <= ST_HEAD;
      r_idx      <= 2'd0;
      r_pair_cnt <= {REP_W{1'b0}};
      r_rep_q    <= rep;
      r_neg_q    <= neg;
      r_out      <= 1'b1;
      r_valid    <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_idx   <= 2'd0;
          r_out   <= 1'b0;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
        ST_HEAD: begin
          r_valid <= 1'b1;
          r_done  <= 1'b0;
          if (r_idx == 2'd3) begin
            r_state    <= ST_MID;
            r_idx      <= 2'd0;
            r_pair_cnt <= REP_W'(1);
            r_out      <= 1'b0;
          end else begin
            r_idx <= r_idx + 2'd1;
            // Head pattern 1,1,1,0: only the step into index 3 emits a zero.
            r_out <= (r_idx != 2'd2);
          end
        end
        ST_MID: begin
          r_valid <= 1'b1;
          r_done  <= 1'b0;
          if (r_idx == 2'd0) begin
            r_idx <= 2'd1;
            r_out <= 1'b1;
          end else if (r_pair_cnt == r_rep_q) begin
            r_state <= ST_TAIL;
            r_idx   <= 2'd0;
            r_out   <= 1'b1;
          end else begin
            r_pair_cnt <= r_pair_cnt + REP_W'(1);
            r_idx      <= 2'd0;
            r_out      <= 1'b0;
          end
        end
        ST_TAIL: begin
          if (r_idx == 2'd0) begin
            r_idx   <= 2'd1;
            r_out   <= ~r_neg_q;
            r_valid <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_pair_cnt <= {REP_W{1'b0}};
            r_out      <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= 2'd0;
          r_out   <= 1'b0;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
